// File: rtl/uart_rx.sv
// Oversampling UART receiver: 2-flop input synchronizer, start-bit glitch
// rejection, mid-bit sampling, stop-bit check, and ready/overrun handshake.
module uart_rx #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx_enb,
  input  logic                 rx,
  input  logic                 rdy_clr,
  output logic [DATA_BITS-1:0] data,
  output logic                 rdy,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam int CW = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
  localparam int IW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [CW-1:0] CNT_HALF = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(OVERSAMPLE - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(DATA_BITS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t               state_q;
  logic [CW-1:0]        cnt_q;
  logic [IW-1:0]        idx_q;
  logic [DATA_BITS-1:0] shift_q;
  logic [DATA_BITS-1:0] data_q;
  logic                 rx_s1_q;
  logic                 rxs_q;
  logic                 rdy_q;
  logic                 frame_err_q;
  logic                 overrun_q;

  // Synchronizer, receive FSM and output registers; FSM advances only on ticks.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      idx_q       <= '0;
      shift_q     <= '0;
      data_q      <= '0;
      rx_s1_q     <= 1'b1;
      rxs_q       <= 1'b1;
      rdy_q       <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      rx_s1_q <= rx;
      rxs_q   <= rx_s1_q;
      if (rdy_clr) begin
        rdy_q     <= 1'b0;
        overrun_q <= 1'b0;
      end
      if (rx_enb) begin
        case (state_q)
          IDLE: begin
            if (!rxs_q) begin
              state_q <= START;
              cnt_q   <= '0;
            end
          end
          START: begin
            if (cnt_q == CNT_HALF) begin
              cnt_q <= '0;
              if (!rxs_q) begin
                state_q <= DATA;
                idx_q   <= '0;
              end else begin
                state_q <= IDLE;
              end
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
          DATA: begin
            if (cnt_q == CNT_LAST) begin
              shift_q[idx_q] <= rxs_q;
              cnt_q          <= '0;
              idx_q          <= idx_q + 1'b1;
              if (idx_q == IDX_LAST) begin
                state_q <= STOP;
              end
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
          STOP: begin
            if (cnt_q == CNT_LAST) begin
              state_q <= IDLE;
              cnt_q   <= '0;
              // A good delivery wins over a same-cycle acknowledge.
              if (rxs_q) begin
                data_q      <= shift_q;
                rdy_q       <= 1'b1;
                frame_err_q <= 1'b0;
                if (rdy_q && !rdy_clr) begin
                  overrun_q <= 1'b1;
                end
              end else begin
                frame_err_q <= 1'b1;
              end
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
          default: begin
            state_q <= IDLE;
            cnt_q   <= '0;
          end
        endcase
      end
    end
  end

  assign data      = data_q;
  assign rdy       = rdy_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter: DATA_BITS, 8, number of data bits per frame, LSB first.
REQ-002 Parameter: OVERSAMPLE, 16, rx_enb ticks per bit period.
REQ-003 Port: clk  input  1  single clock for all logic.
REQ-004 Port: rst  input  1  reset, synchronous and active-high, sampled on posedge clk.
REQ-005 Port: rx_enb  input  1  one-clk-wide oversample tick from the baud rate generator, OVERSAMPLE per bit period.
REQ-006 Port: rx  input  1  asynchronous serial line, idle high.
REQ-007 Port: rdy_clr  input  1  consumer acknowledge; clears rdy and overrun.
REQ-008 Port: data  output  DATA_BITS  last correctly framed byte.
REQ-009 Port: rdy  output  1  data holds an unread byte.
REQ-010 Port: frame_err  output  1  result of the last stop-bit check (1 = bad stop bit).
REQ-011 Port: overrun  output  1  sticky; a byte was delivered while rdy was still set.
REQ-012 Port: busy  output  1  high whenever the state is not IDLE.

Function
REQ-013 rx shall pass through a 2-flop synchronizer (both flops reset to 1); all decisions use the synchronized value rxs.
REQ-014 The FSM shall have four states: IDLE, START, DATA, STOP; the FSM and sample counter cnt (log2(OVERSAMPLE) bits) shall change only on cycles with rx_enb=1 and hold otherwise.
REQ-015 IDLE: on a tick with rxs=0 -> START with cnt<=0; otherwise remain in IDLE.
REQ-016 START: on a tick with cnt==OVERSAMPLE/2-1 (7): if rxs=0 -> DATA with cnt<=0 and bit index<=0; if rxs=1 -> IDLE (glitch rejected, no output change); on other ticks cnt<=cnt+1.
REQ-017 DATA: on a tick with cnt==OVERSAMPLE-1, sample rxs into shift-register bit [index], cnt<=0, index<=index+1; after bit DATA_BITS-1 -> STOP; on other ticks cnt<=cnt+1.
REQ-018 STOP: on a tick with cnt==OVERSAMPLE-1, check the stop bit and -> IDLE; on other ticks cnt<=cnt+1.
REQ-019 Good stop bit (rxs=1): data<=shift register, rdy<=1, frame_err<=0; if rdy was already 1 and rdy_clr=0 in that cycle, overrun<=1 and data is overwritten.
REQ-020 Bad stop bit (rxs=0): frame_err<=1; data, rdy and overrun unchanged.
REQ-021 Outputs shall be registered; rdy/data/frame_err update on the clk edge that ends the stop-bit-sampling tick cycle (1-cycle latency).
REQ-022 rdy_clr=1 shall clear rdy and overrun on the next edge; a same-cycle good-stop delivery takes priority: rdy=1, data=new byte, overrun=0.
REQ-023 Each sample point shall fall 8 ticks after start detection plus 16 ticks per subsequent bit (mid-bit).
REQ-024 A return to IDLE after STOP shall allow a new start bit to be detected on the very next tick.

Reset
REQ-025 When rst=1: state<=IDLE, cnt<=0, index<=0, shift register<=0, synchronizer flops<=1, data<=0, rdy<=0, frame_err<=0, overrun<=0; busy=0.
REQ-026 rst shall override all inputs, including rx_enb and rdy_clr, and shall abort any frame in progress with no output update.

Verification
REQ-027 Frame 0xA5 with good stop bit, 16 ticks per bit -> data=0xA5, rdy=1, frame_err=0, overrun=0, busy=0 after the stop-bit sample.
REQ-028 rx low for 4 ticks then high (glitch) -> FSM returns to IDLE at the 8th tick, rdy stays 0, data unchanged.
REQ-029 Frame 0x3C with stop bit = 0 -> frame_err=1, rdy=0, data retains its previous value.
REQ-030 Frames 0x12 then 0x34 with no rdy_clr -> data=0x34, rdy=1, overrun=1; rdy_clr pulse -> rdy=0, overrun=0.
REQ-031 rdy_clr asserted in the same cycle as a good 0x55 delivery -> rdy=1, data=0x55, overrun=0.
REQ-032 rst pulsed during DATA of one frame, followed by a clean 0xC3 frame -> all outputs 0 after reset, then data=0xC3, rdy=1; rx_enb held low for 100 cycles mid-frame -> no state or cnt change.
